// File: rtl/reg_dump_uart_tx_pkg.sv
// Shared definitions for the register-dump UART transmitter: frame geometry,
// FSM encoding and the byte-lane selector used when serializing a word.
package reg_dump_uart_tx_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         FRAME_BYTES       = 69;
  localparam int         NUM_DUMP_WORDS    = 17;
  localparam logic [4:0] LAST_WORD_IDX     = 5'd16;
  localparam logic [2:0] BYTES_PER_WORD    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_SELECT = 3'd2,
    ST_LOAD   = 3'd3,
    ST_SEND   = 3'd4,
    ST_DONE   = 3'd5
  } dump_state_e;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reg_dump_uart_tx_uart_tx_byte.sv
// 8N1 byte serializer. The final stop-bit cycle is spent in TX_IDLE with
// byte_ready high, so a byte offered then follows with no gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  assign byte_ready = (state_q == TX_IDLE);
  assign tx         = tx_q;

  // Next-state logic for the bit sequencer.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        bit_d  = 3'd0;
        if (byte_valid) begin
          shift_d = byte_data;
          tx_d    = 1'b0;
          state_d = TX_START;
        end else begin
          tx_d    = 1'b1;
        end
      end
      TX_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = TX_DATA;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        // The last stop cycle is the TX_IDLE cycle that follows.
        if (baud_q == STOP_LAST) begin
          baud_d  = '0;
          state_d = TX_IDLE;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Serializer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Debug-port dumper: on start, sends SYNC_BYTE then R0..R15 and fetchPC as
// little-endian 32-bit words over UART, sampling each word in its own LOAD cycle.
module reg_dump_uart_tx
  import reg_dump_uart_tx_pkg::*;
#(
  parameter int         WIDTH        = 32,
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [3:0]       debug_reg_sel,
  input  logic [WIDTH-1:0] debug_reg_out,
  input  logic [WIDTH-1:0] fetchPC,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  dump_state_e      state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [3:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             byte_valid_s, byte_ready_s;
  logic [7:0]       byte_data_s;
  logic [WIDTH-1:0] load_word_s;

  assign debug_reg_sel = sel_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // Frame sequencing, word capture and byte selection.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    sel_d        = sel_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    byte_valid_s = 1'b0;
    byte_data_s  = 8'h00;
    load_word_s  = (idx_q == LAST_WORD_IDX) ? fetchPC : debug_reg_out;
    case (state_q)
      ST_IDLE: begin
        sel_d = 4'd0;
        if (start && byte_ready_s) begin
          byte_valid_s = 1'b1;
          byte_data_s  = SYNC_BYTE;
          busy_d       = 1'b1;
          state_d      = ST_SYNC;
        end else begin
          busy_d       = 1'b0;
        end
      end
      ST_SYNC: begin
        if (byte_ready_s) begin
          idx_d   = 5'd0;
          state_d = ST_SELECT;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_SELECT: begin
        sel_d   = idx_q[3:0];
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Byte 0 leaves straight from the capture mux to keep the word gap at two cycles.
        word_d       = load_word_s;
        byte_valid_s = 1'b1;
        byte_data_s  = word_byte(load_word_s, 2'd0);
        cnt_d        = 3'd1;
        state_d      = ST_SEND;
      end
      ST_SEND: begin
        if (byte_ready_s) begin
          if (cnt_q < BYTES_PER_WORD) begin
            byte_valid_s = 1'b1;
            byte_data_s  = word_byte(word_q, cnt_q[1:0]);
            cnt_d        = cnt_q + 3'd1;
          end else if (idx_q == LAST_WORD_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            sel_d   = 4'd0;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_SELECT;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        sel_d   = 4'd0;
      end
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
      cnt_q   <= 3'd0;
      word_q  <= '0;
      sel_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk        (clk),
    .rst_n      (reset),
    .byte_valid (byte_valid_s),
    .byte_data  (byte_data_s),
    .byte_ready (byte_ready_s),
    .tx         (tx)
  );

endmodule
